// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST frame loader and the inference engine.
//   state_e           : loader FSM states
//   NumPixelsDefault  : pixel bytes per 28x28 image
//   SyncByteDefault   : frame start marker on the UART link
package mnist_pkg;

  typedef enum logic [1:0] {
    StHunt  = 2'd0,
    StLoad  = 2'd1,
    StCheck = 2'd2
  } state_e;

  localparam int unsigned NumPixelsDefault = 784;
  localparam logic [7:0]  SyncByteDefault  = 8'hA5;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's slow byte-ready level into a single-cycle strobe in the clk domain.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   rdy_in  : byte-ready level from the UART receiver (asynchronous to clk)
//   stb_out : one-cycle pulse on each rising edge of rdy_in
module rx_byte_strobe (
  input  logic clk,
  input  logic rst,
  input  logic rdy_in,
  output logic stb_out
);

  logic rdy_meta_q;
  logic rdy_sync_q;
  logic rdy_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_meta_q <= rdy_in;
      rdy_sync_q <= rdy_meta_q;
      rdy_prev_q <= rdy_sync_q;
    end
  end

  assign stb_out = rdy_sync_q & ~rdy_prev_q;

endmodule

// File: rtl/mnist_frame_loader.sv
// Loads one MNIST image from the UART byte stream into pixel RAM.
// Wire format: SYNC_BYTE, NUM_PIXELS pixel bytes, 8-bit modulo-sum checksum.
//   clk, rst              : system clock, asynchronous active-low reset
//   rxdata_rdy, rxdata    : receiver byte-ready level and byte
//   accept_en             : engine idle, a new frame may start
//   mem_we/addr/wdata     : registered pixel RAM write port
//   busy                  : frame in progress (LOAD or CHECK)
//   frame_done, frame_err : one-cycle result pulses (good frame / bad checksum or timeout)
module mnist_frame_loader
  import mnist_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = NumPixelsDefault,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxdata_rdy,
  input  logic [7:0]        rxdata,
  input  logic              accept_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT_CYC);

  logic byte_stb;

  rx_byte_strobe u_rx_byte_strobe (
    .clk     (clk),
    .rst     (rst),
    .rdy_in  (rxdata_rdy),
    .stb_out (byte_stb)
  );

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (byte_stb && accept_en && (rxdata == SYNC_BYTE)) begin
          state_d = StLoad;
          cnt_d   = '0;
          sum_d   = '0;
          timer_d = '0;
        end
      end
      StLoad, StCheck: begin
        // Timeout takes priority over a byte arriving in the same cycle.
        if (timer_q == TimerMax) begin
          err_d   = 1'b1;
          state_d = StHunt;
        end else if (byte_stb) begin
          timer_d = '0;
          if (state_q == StLoad) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = rxdata;
            sum_d   = sum_q + rxdata;
            cnt_d   = cnt_q + ADDR_W'(1);
            if (cnt_q == LastAddr) state_d = StCheck;
          end else begin
            done_d  = (rxdata == sum_q);
            err_d   = (rxdata != sum_q);
            state_d = StHunt;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StHunt;
    endcase
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q == StLoad) || (state_q == StCheck);
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Scoreboard bench: stimulus pushes the expected RAM writes and frame results, a monitor pops
// and compares whenever the loader produces a write or a result pulse.
module tb_mnist_frame_loader;

  localparam int unsigned NPix    = 784;
  localparam int unsigned AddrW   = 10;
  localparam int unsigned Timeout = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rxdata_rdy = 1'b0;
  logic [7:0]       rxdata = 8'h00;
  logic             accept_en = 1'b1;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic             busy;
  logic             frame_done;
  logic             frame_err;

  mnist_frame_loader #(
    .NUM_PIXELS  (NPix),
    .ADDR_W      (AddrW),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxdata_rdy (rxdata_rdy),
    .rxdata     (rxdata),
    .accept_en  (accept_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 write, 1 frame_done, 2 frame_err
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_rise_cyc = 0;
  int  last_err_cyc = 0;
  logic [7:0] pix [NPix];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed write/result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (mem_we || frame_done || frame_err)) begin
      ev_t e;
      int  k;
      check("done_err_exclusive", int'(frame_done & frame_err), 0);
      k = mem_we ? 0 : (frame_done ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_event_kind", k, -1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        if (e.kind == 0) begin
          check("write_addr", int'(mem_addr), e.addr);
          check("write_data", int'(mem_wdata), e.data);
        end else begin
          check("busy_after_result", int'(busy), 0);
        end
        if (k == 2) last_err_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rxdata        = b;
    rxdata_rdy    = 1'b1;
    last_rise_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 rxdata_rdy = 1'b0;
    repeat (3 + $urandom_range(0, 1)) @(posedge clk);
  endtask

  // Sends sync plus the first npix pixels of pix[]; a full frame also gets its checksum,
  // optionally corrupted by +1.
  task automatic send_frame(input int npix, input bit corrupt);
    int   s = 0;
    ev_t  e;
    send_byte(8'hA5);
    for (int i = 0; i < npix; i++) begin
      e.kind = 0; e.addr = i; e.data = int'(pix[i]);
      exp_q.push_back(e);
      s = (s + int'(pix[i])) % 256;
      send_byte(pix[i]);
    end
    if (npix == NPix) begin
      e.kind = corrupt ? 2 : 1; e.addr = 0; e.data = 0;
      exp_q.push_back(e);
      send_byte(corrupt ? 8'((s + 1) % 256) : 8'(s));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPix; i++) pix[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPix; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    ev_t e;
    #12;
    check("reset_we", int'(mem_we), 0);
    check("reset_addr", int'(mem_addr), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_result", int'(frame_done | frame_err), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Good ramp frame, then the same frame with a bad checksum.
    fill_ramp();
    send_frame(NPix, 1'b0);
    drain("good_ramp");
    send_frame(NPix, 1'b1);
    drain("bad_checksum");

    // Non-sync bytes and a sync byte with accept_en low must be dropped.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    accept_en = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 8'hA4)));
    check("hunt_busy", int'(busy), 0);
    accept_en = 1'b1;
    fill_random();
    send_frame(NPix, 1'b0);
    drain("after_hunt");

    // Pixel bytes equal to the sync value are data.
    for (int i = 0; i < NPix; i++) pix[i] = 8'hA5;
    send_frame(NPix, 1'b0);
    drain("embedded_sync");

    // Stall after 100 pixels: one timeout error, then a normal frame.
    fill_random();
    send_frame(100, 1'b0);
    e.kind = 2; e.addr = 0; e.data = 0;
    exp_q.push_back(e);
    drain("timeout");
    check("timeout_latency_ok",
          int'((last_err_cyc - last_rise_cyc) >= 1000 && (last_err_cyc - last_rise_cyc) <= 1008), 1);
    check("timeout_busy", int'(busy), 0);
    fill_random();
    send_frame(NPix, ($urandom_range(0, 1) == 1));
    drain("after_timeout");

    // accept_en dropping mid-frame does not abort it.
    fill_random();
    fork
      send_frame(NPix, 1'b0);
      begin
        repeat (2000) @(posedge clk);
        accept_en = 1'b0;
      end
    join
    accept_en = 1'b1;
    drain("accept_drop");

    // Asynchronous reset in the middle of a frame.
    fill_random();
    send_frame(300, 1'b0);
    drain("pre_reset");
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_we", int'(mem_we), 0);
    check("arst_addr", int'(mem_addr), 0);
    check("arst_wdata", int'(mem_wdata), 0);
    check("arst_result", int'(frame_done | frame_err), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    fill_random();
    send_frame(NPix, 1'b0);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
